// File: rtl/ps2_key_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame states, scancodes, held-key indices.
// Pure declarations; no timing or flow control.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_AA    = 8'hAA;
  localparam logic [7:0] SC_FA    = 8'hFA;
  localparam logic [7:0] SC_EE    = 8'hEE;
  localparam logic [7:0] SC_FC    = 8'hFC;
  localparam logic [7:0] SC_FE    = 8'hFE;
  localparam logic [7:0] SC_00    = 8'h00;
  localparam logic [7:0] SC_FF    = 8'hFF;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int HELD_LEFT  = 0;
  localparam int HELD_RIGHT = 1;
  localparam int HELD_DOWN  = 2;
  localparam int HELD_UP    = 3;
  localparam int HELD_SPACE = 4;

  // Controller responses and Pause/BAT noise that must never reach the game logic.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_E1) || (b == SC_AA) || (b == SC_FA) || (b == SC_EE) ||
           (b == SC_FC) || (b == SC_FE) || (b == SC_00) || (b == SC_FF);
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key-event bus from the PS/2 receiver to the game logic.
// Pulses only, no backpressure: the consumer must take an event in its pulse cycle.
interface ps2_key_rx_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [4:0] key_held;
  logic       frame_err;
  logic       busy;

  modport master (output key_valid, key_code, key_ext, key_break, key_held, frame_err, busy);
  modport slave  (input  key_valid, key_code, key_ext, key_break, key_held, frame_err, busy);
endinterface

// File: rtl/ps2_key_rx_line_sync.sv
// Synchronises raw PS/2 pins and glitch-filters the clock; strobe on filtered falling edge.
// Latency: 2 sync cycles + FILTER_LEN cycles from raw edge to strobe; no backpressure.
module ps2_line_sync #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_b,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall_strobe,
  output logic dat_s
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          toggle;

  assign toggle      = (clk_sync[1] != level) && (cnt == CW'(FILTER_LEN - 1));
  assign fall_strobe = toggle && level;
  assign dat_s       = dat_sync[1];

  // Synchronisers reset to the idle-high line state so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      level    <= 1'b1;
      cnt      <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      if (clk_sync[1] == level) begin
        cnt <= '0;
      end else if (toggle) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes bytes, folds E0/F0 prefixes into key events, tracks held game keys.
// Events and frame errors are registered one cycle after the STOP strobe; no backpressure.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ps2_clk,
  input  logic         ps2_dat,
  ps2_key_rx_if.master key_bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          strobe;
  logic          dat_s;
  frame_state_t  state, state_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shreg, sh_nx;
  logic          par, par_nx;
  logic [TW-1:0] to_cnt, to_nx;
  logic          byte_ok, frame_bad;

  logic          ext_pend, brk_pend;
  logic          key_valid_q, key_ext_q, key_break_q, frame_err_q;
  logic [7:0]    key_code_q;
  logic [4:0]    key_held_q;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk         (clk),
    .rst_b       (rst_b),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .fall_strobe (strobe),
    .dat_s       (dat_s)
  );

  always_comb begin
    state_nx  = state;
    bit_nx    = bit_cnt;
    sh_nx     = shreg;
    par_nx    = par;
    to_nx     = to_cnt;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        to_nx = '0;
        if (strobe && !dat_s) begin
          state_nx = DATA;
          bit_nx   = 3'd0;
        end
      end
      DATA: begin
        if (strobe) begin
          sh_nx  = {dat_s, shreg[7:1]};
          bit_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_nx   = dat_s;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          if (dat_s && (^{shreg, par})) byte_ok = 1'b1;
          else                           frame_bad = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A strobe landing on the expiry cycle keeps the frame alive.
    if (state != IDLE) begin
      if (strobe) begin
        to_nx = '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_bad = 1'b1;
        state_nx  = IDLE;
        to_nx     = '0;
      end else begin
        to_nx = to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      to_cnt      <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_held_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_nx;
      shreg       <= sh_nx;
      par         <= par_nx;
      to_cnt      <= to_nx;
      key_valid_q <= 1'b0;
      frame_err_q <= frame_bad;
      if (frame_bad) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == SC_E0) begin
          ext_pend <= 1'b1;
        end else if (shreg == SC_F0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (!is_ignored(shreg)) begin
            key_valid_q <= 1'b1;
            key_code_q  <= shreg;
            key_ext_q   <= ext_pend;
            key_break_q <= brk_pend;
            if (ext_pend && shreg == SC_LEFT)   key_held_q[HELD_LEFT]  <= ~brk_pend;
            if (ext_pend && shreg == SC_RIGHT)  key_held_q[HELD_RIGHT] <= ~brk_pend;
            if (ext_pend && shreg == SC_DOWN)   key_held_q[HELD_DOWN]  <= ~brk_pend;
            if (ext_pend && shreg == SC_UP)     key_held_q[HELD_UP]    <= ~brk_pend;
            if (!ext_pend && shreg == SC_SPACE) key_held_q[HELD_SPACE] <= ~brk_pend;
          end
        end
      end
    end
  end

  assign key_bus.key_valid = key_valid_q;
  assign key_bus.key_code  = key_code_q;
  assign key_bus.key_ext   = key_ext_q;
  assign key_bus.key_break = key_break_q;
  assign key_bus.key_held  = key_held_q;
  assign key_bus.frame_err = frame_err_q;
  assign key_bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: PS/2 frame driver, key-event reference model and scoreboard monitor.
module tb_ps2_key_rx;

  localparam int FL = 4;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_fall = 0;

  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .key_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       is_err;
    bit [7:0] code;
    bit       ext;
    bit       brk;
    bit [4:0] held;
    bit       chk_win;
    int       lo;
    int       hi;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what a keyboard user would say is pending / held.
  bit       m_ext = 0;
  bit       m_brk = 0;
  bit [4:0] m_held = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_byte(input bit [7:0] b, input bit good);
    exp_t e;
    int   idx;
    e = '{default: 0};
    if (!good) begin
      e.is_err = 1;
      exp_q.push_back(e);
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      idx = -1;
      if (m_ext) begin
        case (b)
          8'h6B: idx = 0;
          8'h74: idx = 1;
          8'h72: idx = 2;
          8'h75: idx = 3;
          default: idx = -1;
        endcase
      end else if (b == 8'h29) begin
        idx = 4;
      end
      if (idx >= 0) m_held[idx] = !m_brk;
      e.code = b;
      e.ext  = m_ext;
      e.brk  = m_brk;
      e.held = m_held;
      exp_q.push_back(e);
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    ps2_dat = b;
    wait_clk(25);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_clk(50);
    ps2_clk = 1'b1;
    wait_clk(25);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop);
    bit p;
    p = ~(^b) ^ bad_par;
    model_byte(b, !bad_par && !bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(~bad_stop);
    ps2_dat = 1'b1;
    wait_clk(100);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_code"},  bus.key_code, 0);
    chk({tag, "_held"},  bus.key_held, 0);
    chk({tag, "_flags"}, {bus.key_valid, bus.key_ext, bus.key_break, bus.frame_err, bus.busy}, 0);
  endtask

  // Monitor: every pulse on the bus must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b && (bus.key_valid || bus.frame_err)) begin
        chk("valid_err_excl", bus.key_valid & bus.frame_err, 0);
        chk("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("event_kind", bus.frame_err, e.is_err);
          chk("busy_at_event", bus.busy, 0);
          if (!e.is_err) begin
            chk("key_code",  bus.key_code, e.code);
            chk("key_ext",   bus.key_ext, e.ext);
            chk("key_break", bus.key_break, e.brk);
            chk("key_held",  bus.key_held, e.held);
          end
          if (e.chk_win) begin
            chk("timeout_lo", cyc >= e.lo, 1);
            chk("timeout_hi", cyc <= e.hi, 1);
          end
        end
      end
    end
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  bit [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29,
                          8'h1C, 8'hAA, 8'hFA, 8'h12, 8'h5A, 8'hE1, 8'h00};

  initial begin
    int   busy_seen;
    int   wait_n;
    exp_t e;

    wait_clk(3);
    check_all_zero("reset_held");
    rst_b = 1'b1;
    wait_clk(2);
    check_all_zero("after_reset");

    send_frame(8'h1C, 0, 0);

    send_frame(8'hE0, 0, 0);
    send_frame(8'h6B, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);

    send_frame(8'h29, 1, 0);
    send_frame(8'h29, 0, 0);

    // Short low glitch while idle with data high must never start a frame.
    busy_seen = 0;
    ps2_dat = 1'b1;
    ps2_clk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_clk(1);
      if (bus.busy) busy_seen++;
    end
    ps2_clk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wait_clk(1);
      if (bus.busy) busy_seen++;
    end
    chk("glitch_busy", busy_seen, 0);

    send_frame(8'h1C, 0, 1);

    // Release space, then a dangling F0 that the timeout must cancel.
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    e = '{default: 0};
    e.is_err  = 1;
    e.chk_win = 1;
    e.lo      = last_fall + TO + 4;
    e.hi      = last_fall + TO + 8;
    exp_q.push_back(e);
    m_ext = 0;
    m_brk = 0;
    wait_clk(TO + 200);
    chk("timeout_drained", exp_q.size(), 0);
    send_frame(8'h29, 0, 0);

    // Reset mid-frame with F0 pending: no event, no error, all outputs cleared.
    send_frame(8'hF0, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_b = 1'b0;
    wait_clk(1);
    rst_b = 1'b1;
    m_ext = 0;
    m_brk = 0;
    m_held = 0;
    check_all_zero("mid_reset");
    wait_clk(300);
    send_frame(8'h1C, 0, 0);

    for (int n = 0; n < 24; n++) begin
      bit bp, bs;
      bp = ($urandom_range(7) == 0);
      bs = !bp && ($urandom_range(7) == 0);
      send_frame(pool[$urandom_range(13)], bp, bs);
    end

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 2000) begin
      wait_clk(1);
      wait_n++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
# ps2_key_rx

PS/2 keyboard receiver feeding key events to the game logic (tetris, snake, game of life) in the DE2-115 top level. It synchronises and filters the raw PS2_CLK/PS2_DAT lines, deframes 11-bit device-to-host frames, and checks parity, start and stop bits. It folds the E0/F0 prefixes into one event per key, and keeps a held-key vector for the game controls.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples needed before the filtered ps2 clock changes level.
- TIMEOUT_CYCLES, 100_000: idle clk cycles allowed between bit edges inside a frame (2 ms at 50 MHz).

Ports:
- clk  input  1  50 MHz system clock (CLOCK_50).
- rst_b  input  1  reset; one clock, reset is synchronous and active-low.
- ps2_clk  input  1  raw PS2_CLK pin (asynchronous).
- ps2_dat  input  1  raw PS2_DAT pin (asynchronous).
- key_valid  output  1  one-cycle pulse: key event present.
- key_code  output  8  scancode of the event; held until the next event.
- key_ext  output  1  event was E0-prefixed.
- key_break  output  1  event was a release (F0-prefixed).
- key_held  output  5  {space, up, down, right, left}; 1 = key currently pressed.
- frame_err  output  1  one-cycle pulse: frame discarded (parity, start, stop or timeout).
- busy  output  1  frame FSM not in IDLE.

## Operation
- Both pins pass through a 2-flop synchroniser.
- The synchronised clock feeds a filter with a count of 0..FILTER_LEN-1:
  - The count resets whenever the sample equals the filtered level.
  - The filtered level toggles when FILTER_LEN consecutive samples differ from it.
  - A falling edge of the filtered level is the sample strobe. Data is taken from the synchronised ps2_dat on the strobe cycle.
- Frame FSM states:
  - IDLE: on a strobe, data 0 means start → DATA with bit counter 0. Data 1 is ignored.
  - DATA: shift in LSB first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop is 1 and the XOR of the 8 data bits and parity is 1 (odd parity), emit the byte. Otherwise pulse frame_err. Either way → IDLE.
- Timeout: in any non-IDLE state, a cycle counter runs between strobes. Reaching TIMEOUT_CYCLES pulses frame_err and returns to IDLE. A strobe on the same cycle wins: the counter clears and there is no error.
- Byte decoder, applied to each good byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - 0xE1, 0xAA, 0xFA, 0xEE, 0xFC, 0xFE, 0x00 and 0xFF are ignored and clear both pending flags.
  - Any other byte pulses key_valid with key_code = byte, key_ext = ext_pend and key_break = brk_pend, then clears both flags.
  - The Pause sequence therefore yields ordinary events for 14/77. This is accepted.
- On any frame_err, both pending flags clear.
- key_held bit mapping:
  - left: E0 6B.
  - right: E0 74.
  - down: E0 72.
  - up: E0 75.
  - space: 0x29 with no E0 prefix.
- On a matching event, the key_held bit is set when key_break = 0 and cleared when key_break = 1.

## Timing
- Reset values:
  - All outputs are 0: key_code = 8'h00, key_held = 5'b0, key_valid, key_ext, key_break, frame_err and busy all 0.
  - Filtered clock level is 1, FSM is IDLE, counters and pending flags are 0.
- Reset asserted mid-frame discards the frame, with no frame_err and no event.
- Pin to strobe: 2 synchroniser cycles + FILTER_LEN cycles after a raw falling edge.
- key_valid or frame_err asserts on the cycle after the STOP strobe (registered), for exactly 1 cycle.
- key_code, key_ext, key_break and key_held update on the same edge that raises key_valid.
- key_valid and frame_err are never both high.
- busy rises on the cycle after the start strobe. It falls with the key_valid, frame_err or ignored-byte cycle, or on the cycle after a timeout.
- No backpressure: the consumer must take an event in its pulse cycle.

## Structure
- Package ps2_pkg holds:
  - the frame-state enum (IDLE, DATA, PARITY, STOP);
  - scancode localparams: E0, F0, the ignored codes, left/right/up/down/space;
  - key_held bit-index constants.
- Sub-module ps2_line_sync: the synchronisers, the FILTER_LEN clock filter and falling-edge strobe. Its outputs are fall_strobe and dat_s.
- ps2_key_rx holds the frame FSM, timeout counter, byte decoder and held vector.

## Test plan
Bench uses FILTER_LEN = 4, TIMEOUT_CYCLES = 1000, and a bit period of 100 clk (50 low / 50 high).
- Frame 0x1C with odd parity → single key_valid, key_code = 1C, ext = 0, brk = 0, key_held = 0.
- Bytes E0 6B → one event: key_code = 6B, ext = 1, key_held[0] = 1. Then E0 F0 6B → brk = 1, ext = 1, key_held[0] = 0.
- 0x29 frame with the parity bit flipped → frame_err pulse, no key_valid. Then a good 0x29 → event with brk = 0, not brk = 1.
- 5-cycle glitch low on ps2_clk in IDLE → no strobe, busy stays 0. Stop bit driven 0 → frame_err.
- Frame abandoned after 4 bits → frame_err exactly TIMEOUT_CYCLES after the last strobe, busy = 0. A following good 0x29 → held space = 1.
- rst_b low for 1 cycle mid-frame after a pending F0 → all outputs 0, no event. The next frame 0x1C decodes with brk = 0.
